vga_fade_stage: RTL and testbench

// - Frame-synchronous brightness fader inserted at the end of the vga display chain, directly upstream of the

---
 rtl/vga_fade_stage_if.sv | 14 +
 rtl/vga_fade_stage.sv | 168 ++++++++++++++++
 tb/tb_vga_fade_stage.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/vga_fade_stage_if.sv
// rtl/vga_fade_stage_if.sv - vga chain bundle shared by display pipeline stages
interface vga;
    logic [10:0] pxl_x;
    logic [10:0] pxl_y;
    logic [3:0]  red;
    logic [3:0]  green;
    logic [3:0]  blue;
    logic        hsync;
    logic        vsync;
    logic        en;

    modport in  (input  pxl_x, pxl_y, red, green, blue, hsync, vsync, en);
    modport out (output pxl_x, pxl_y, red, green, blue, hsync, vsync, en);
endinterface

// File: rtl/vga_fade_stage.sv
// rtl/vga_fade_stage.sv - frame-synchronous brightness fader at the end of the vga chain
module vga_fade_stage #(
    parameter int FRAMES_PER_STEP = 4,
    parameter bit START_VISIBLE   = 1'b1,
    parameter bit VSYNC_ACTIVE    = 1'b0
) (
    input  logic       clk_25,
    input  logic       resetN,
    vga.in             vga_in,
    vga.out            vga_out,
    input  logic       fade_out_req,
    input  logic       fade_in_req,
    output logic       busy,
    output logic       done,
    output logic [4:0] level
);

    localparam logic [1:0] S_ON         = 2'd0;
    localparam logic [1:0] S_OFF        = 2'd1;
    localparam logic [1:0] S_FADING_OUT = 2'd2;
    localparam logic [1:0] S_FADING_IN  = 2'd3;

    localparam logic [1:0] RESET_STATE = START_VISIBLE ? S_ON : S_OFF;
    localparam logic [4:0] RESET_LEVEL = START_VISIBLE ? 5'd16 : 5'd0;
    localparam logic [7:0] LAST_COUNT  = 8'(FRAMES_PER_STEP - 1);

    logic [10:0] r_pxl_x;
    logic [10:0] r_pxl_y;
    logic [3:0]  r_red;
    logic [3:0]  r_green;
    logic [3:0]  r_blue;
    logic        r_hsync;
    logic        r_vsync;
    logic        r_en;

    logic [1:0]  r_state;
    logic [4:0]  r_level;
    logic [7:0]  r_cnt;
    logic        r_done;

    logic [1:0]  w_state_nxt;
    logic [4:0]  w_level_nxt;
    logic [7:0]  w_cnt_nxt;
    logic        w_done_nxt;
    logic        w_tick;

    // colour * level / 16; the 9-bit product is truncated back to 4 bits
    function automatic logic [3:0] scale(input logic [3:0] c, input logic [4:0] l);
        return 4'(({5'd0, c} * {4'd0, l}) >> 4);
    endfunction

    // The registered vsync doubles as the previous-vsync sample for edge detection
    assign w_tick = (r_vsync != VSYNC_ACTIVE) && (vga_in.vsync == VSYNC_ACTIVE);

    // Next-state logic: request handling, frame counting and level stepping
    always_comb begin
        w_state_nxt = r_state;
        w_level_nxt = r_level;
        w_cnt_nxt   = r_cnt;
        w_done_nxt  = 1'b0;
        case (r_state)
            S_ON: begin
                if (fade_out_req) begin
                    w_state_nxt = S_FADING_OUT;
                    w_cnt_nxt   = '0;
                end
            end
            S_OFF: begin
                if (fade_in_req) begin
                    w_state_nxt = S_FADING_IN;
                    w_cnt_nxt   = '0;
                end
            end
            S_FADING_OUT: begin
                // fade_out_req has priority, so only a lone fade_in_req reverses
                if (fade_in_req && !fade_out_req) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = (r_level == 5'd16) ? S_ON : S_FADING_IN;
                end else if (w_tick) begin
                    if (r_cnt == LAST_COUNT) begin
                        w_cnt_nxt   = '0;
                        w_level_nxt = r_level - 5'd1;
                        if (r_level == 5'd1) begin
                            w_state_nxt = S_OFF;
                            w_done_nxt  = 1'b1;
                        end
                    end else begin
                        w_cnt_nxt = r_cnt + 8'd1;
                    end
                end
            end
            S_FADING_IN: begin
                if (fade_out_req) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = (r_level == 5'd0) ? S_OFF : S_FADING_OUT;
                end else if (w_tick) begin
                    if (r_cnt == LAST_COUNT) begin
                        w_cnt_nxt   = '0;
                        w_level_nxt = r_level + 5'd1;
                        if (r_level == 5'd15) begin
                            w_state_nxt = S_ON;
                            w_done_nxt  = 1'b1;
                        end
                    end else begin
                        w_cnt_nxt = r_cnt + 8'd1;
                    end
                end
            end
            default: begin
                w_state_nxt = RESET_STATE;
                w_level_nxt = RESET_LEVEL;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    // Control state registers
    always_ff @(posedge clk_25 or negedge resetN) begin
        if (!resetN) begin
            r_state <= RESET_STATE;
            r_level <= RESET_LEVEL;
            r_cnt   <= '0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_level <= w_level_nxt;
            r_cnt   <= w_cnt_nxt;
            r_done  <= w_done_nxt;
        end
    end

    // One-stage datapath; colours scaled by the level held before this edge
    always_ff @(posedge clk_25 or negedge resetN) begin
        if (!resetN) begin
            r_pxl_x <= '0;
            r_pxl_y <= '0;
            r_red   <= '0;
            r_green <= '0;
            r_blue  <= '0;
            r_hsync <= 1'b0;
            r_vsync <= 1'b0;
            r_en    <= 1'b0;
        end else begin
            r_pxl_x <= vga_in.pxl_x;
            r_pxl_y <= vga_in.pxl_y;
            r_red   <= scale(vga_in.red,   r_level);
            r_green <= scale(vga_in.green, r_level);
            r_blue  <= scale(vga_in.blue,  r_level);
            r_hsync <= vga_in.hsync;
            r_vsync <= vga_in.vsync;
            r_en    <= vga_in.en;
        end
    end

    assign vga_out.pxl_x = r_pxl_x;
    assign vga_out.pxl_y = r_pxl_y;
    assign vga_out.red   = r_red;
    assign vga_out.green = r_green;
    assign vga_out.blue  = r_blue;
    assign vga_out.hsync = r_hsync;
    assign vga_out.vsync = r_vsync;
    assign vga_out.en    = r_en;

    assign busy  = (r_state == S_FADING_OUT) || (r_state == S_FADING_IN);
    assign done  = r_done;
    assign level = r_level;

endmodule

// File: tb/tb_vga_fade_stage.sv
// tb/tb_vga_fade_stage.sv - directed self-checking bench for vga_fade_stage
module tb_vga_fade_stage;

    logic       clk = 1'b0;
    logic       resetN;
    logic       out_req1, in_req1, out_req4, in_req4;
    logic       busy1, done1, busy4, done4;
    logic [4:0] level1, level4;
    int         n_cmp = 0;
    int         n_bad = 0;

    vga vin ();
    vga vout1 ();
    vga vout4 ();

    always #20 clk = ~clk;

    vga_fade_stage #(.FRAMES_PER_STEP(1), .START_VISIBLE(1'b1), .VSYNC_ACTIVE(1'b0)) dut1 (
        .clk_25(clk), .resetN(resetN), .vga_in(vin), .vga_out(vout1),
        .fade_out_req(out_req1), .fade_in_req(in_req1),
        .busy(busy1), .done(done1), .level(level1)
    );

    vga_fade_stage #(.FRAMES_PER_STEP(4), .START_VISIBLE(1'b0), .VSYNC_ACTIVE(1'b0)) dut4 (
        .clk_25(clk), .resetN(resetN), .vga_in(vin), .vga_out(vout4),
        .fade_out_req(out_req4), .fade_in_req(in_req4),
        .busy(busy4), .done(done4), .level(level4)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        resetN = 1'b0;
        out_req1 = 1'b0; in_req1 = 1'b0; out_req4 = 1'b0; in_req4 = 1'b0;
        vin.pxl_x = 11'd5; vin.pxl_y = 11'd7;
        vin.red = 4'hF; vin.green = 4'h8; vin.blue = 4'h3;
        vin.hsync = 1'b1; vin.vsync = 1'b1; vin.en = 1'b1;
        repeat (3) step();
        n_cmp++;
        if ({vout1.red, vout1.green, vout1.blue, vout1.pxl_x, vout1.pxl_y, vout1.hsync, vout1.vsync, vout1.en} !== '0) begin
            n_bad++; $display("FAIL rst_out1 got r%h g%h b%h x%0d y%0d want all 0", vout1.red, vout1.green, vout1.blue, vout1.pxl_x, vout1.pxl_y);
        end
        n_cmp++;
        if ({busy1, done1, level1} !== {2'b00, 5'd16}) begin
            n_bad++; $display("FAIL rst_ctl1 got %b want %b", {busy1, done1, level1}, {2'b00, 5'd16});
        end
        n_cmp++;
        if ({busy4, done4, level4} !== 7'd0) begin
            n_bad++; $display("FAIL rst_ctl4 got %b want %b", {busy4, done4, level4}, 7'd0);
        end
        resetN = 1'b1;
        step();
        n_cmp++;
        if ({vout1.red, vout1.green, vout1.blue} !== 12'hF83) begin
            n_bad++; $display("FAIL pass_colour got %h want F83", {vout1.red, vout1.green, vout1.blue});
        end
        n_cmp++;
        if ({vout1.pxl_x, vout1.pxl_y, vout1.hsync, vout1.vsync, vout1.en} !== {11'd5, 11'd7, 3'b111}) begin
            n_bad++; $display("FAIL pass_sync got x%0d y%0d %b want x5 y7 111", vout1.pxl_x, vout1.pxl_y, {vout1.hsync, vout1.vsync, vout1.en});
        end
        n_cmp++;
        if ({vout4.red, vout4.green, vout4.blue, vout4.pxl_x} !== {12'h000, 11'd5}) begin
            n_bad++; $display("FAIL off_colour got %h x%0d want 000 x5", {vout4.red, vout4.green, vout4.blue}, vout4.pxl_x);
        end
        vin.pxl_x = 11'd6; vin.pxl_y = 11'd8;
        #1;
        n_cmp++;
        if (vout1.pxl_x !== 11'd5) begin
            n_bad++; $display("FAIL latency_hold got x%0d want x5", vout1.pxl_x);
        end
        step();
        n_cmp++;
        if ({vout1.pxl_x, vout1.pxl_y} !== {11'd6, 11'd8}) begin
            n_bad++; $display("FAIL latency_one got x%0d y%0d want x6 y8", vout1.pxl_x, vout1.pxl_y);
        end
    endtask

    task automatic test_fade_out_step1();
        out_req1 = 1'b1; step(); out_req1 = 1'b0;
        n_cmp++;
        if ({busy1, done1, level1} !== {2'b10, 5'd16}) begin
            n_bad++; $display("FAIL fo_start got %b want %b", {busy1, done1, level1}, {2'b10, 5'd16});
        end
        for (int k = 1; k <= 16; k++) begin
            vin.vsync = 1'b0; step();
            n_cmp++;
            if ({done1, level1} !== {(k == 16), 5'(16 - k)}) begin
                n_bad++; $display("FAIL fo_tick k=%0d got done%b lvl%0d want done%b lvl%0d", k, done1, level1, (k == 16), 16 - k);
            end
            step();
            n_cmp++;
            if ({done1, level1} !== {1'b0, 5'(16 - k)}) begin
                n_bad++; $display("FAIL fo_vs_held k=%0d got done%b lvl%0d want done0 lvl%0d", k, done1, level1, 16 - k);
            end
            vin.vsync = 1'b1; step(); step();
            n_cmp++;
            if (level1 !== 5'(16 - k)) begin
                n_bad++; $display("FAIL fo_midline k=%0d got lvl%0d want lvl%0d", k, level1, 16 - k);
            end
            if (k == 8) begin
                n_cmp++;
                if ({vout1.red, vout1.green, vout1.blue} !== 12'h741) begin
                    n_bad++; $display("FAIL fo_half got %h want 741", {vout1.red, vout1.green, vout1.blue});
                end
            end
        end
        n_cmp++;
        if ({busy1, done1, vout1.red, vout1.green, vout1.blue} !== 14'd0) begin
            n_bad++; $display("FAIL fo_end got busy%b done%b col%h want busy0 done0 col000", busy1, done1, {vout1.red, vout1.green, vout1.blue});
        end
    endtask

    task automatic test_fade_in_step4();
        in_req4 = 1'b1; step(); in_req4 = 1'b0;
        n_cmp++;
        if ({busy4, done4, level4} !== 7'b10_00000) begin
            n_bad++; $display("FAIL fi_start got %b want 1000000", {busy4, done4, level4});
        end
        for (int t = 1; t <= 64; t++) begin
            vin.vsync = 1'b0; step();
            n_cmp++;
            if ({done4, level4} !== {(t == 64), 5'(t / 4)}) begin
                n_bad++; $display("FAIL fi_tick t=%0d got done%b lvl%0d want done%b lvl%0d", t, done4, level4, (t == 64), t / 4);
            end
            vin.vsync = 1'b1; step();
            n_cmp++;
            if ({done4, level4} !== {1'b0, 5'(t / 4)}) begin
                n_bad++; $display("FAIL fi_line t=%0d got done%b lvl%0d want done0 lvl%0d", t, done4, level4, t / 4);
            end
        end
        n_cmp++;
        if ({busy4, level4, vout4.red, vout4.green, vout4.blue} !== {1'b0, 5'd16, 12'hF83}) begin
            n_bad++; $display("FAIL fi_end got busy%b lvl%0d col%h want busy0 lvl16 colF83", busy4, level4, {vout4.red, vout4.green, vout4.blue});
        end
    endtask

    task automatic test_reversal();
        in_req1 = 1'b1; step(); in_req1 = 1'b0;
        for (int k = 1; k <= 16; k++) begin
            vin.vsync = 1'b0; step();
            n_cmp++;
            if ({done1, level1} !== {(k == 16), 5'(k)}) begin
                n_bad++; $display("FAIL up_tick k=%0d got done%b lvl%0d want done%b lvl%0d", k, done1, level1, (k == 16), k);
            end
            vin.vsync = 1'b1; step();
        end
        out_req1 = 1'b1; step(); out_req1 = 1'b0;
        repeat (6) begin vin.vsync = 1'b0; step(); vin.vsync = 1'b1; step(); end
        n_cmp++;
        if ({busy1, level1} !== {1'b1, 5'd10}) begin
            n_bad++; $display("FAIL rev_at10 got busy%b lvl%0d want busy1 lvl10", busy1, level1);
        end
        out_req1 = 1'b1; in_req1 = 1'b1; step(); out_req1 = 1'b0; in_req1 = 1'b0;
        vin.vsync = 1'b0; step();
        n_cmp++;
        if ({busy1, done1, level1} !== {2'b10, 5'd9}) begin
            n_bad++; $display("FAIL both_req got %b want %b", {busy1, done1, level1}, {2'b10, 5'd9});
        end
        vin.vsync = 1'b1; step();
        in_req1 = 1'b1; step(); in_req1 = 1'b0;
        n_cmp++;
        if ({busy1, done1, level1} !== {2'b10, 5'd9}) begin
            n_bad++; $display("FAIL rev_start got %b want %b", {busy1, done1, level1}, {2'b10, 5'd9});
        end
        for (int k = 1; k <= 7; k++) begin
            vin.vsync = 1'b0; step();
            n_cmp++;
            if ({done1, level1} !== {(k == 7), 5'(9 + k)}) begin
                n_bad++; $display("FAIL rev_tick k=%0d got done%b lvl%0d want done%b lvl%0d", k, done1, level1, (k == 7), 9 + k);
            end
            vin.vsync = 1'b1; step();
        end
        in_req1 = 1'b1;
        repeat (2) begin vin.vsync = 1'b0; step(); vin.vsync = 1'b1; step(); end
        n_cmp++;
        if ({busy1, done1, level1} !== {2'b00, 5'd16}) begin
            n_bad++; $display("FAIL on_ignore got %b want %b", {busy1, done1, level1}, {2'b00, 5'd16});
        end
        in_req1 = 1'b0;
    endtask

    task automatic test_async_reset();
        out_req1 = 1'b1; step(); out_req1 = 1'b0;
        repeat (3) begin vin.vsync = 1'b0; step(); vin.vsync = 1'b1; step(); end
        n_cmp++;
        if ({level1, vout1.red, vout1.green, vout1.blue} !== {5'd13, 12'hC62}) begin
            n_bad++; $display("FAIL pre_rst got lvl%0d col%h want lvl13 colC62", level1, {vout1.red, vout1.green, vout1.blue});
        end
        @(posedge clk);
        #5 resetN = 1'b0;
        #1;
        n_cmp++;
        if ({vout1.red, vout1.green, vout1.blue, vout1.pxl_x, vout1.vsync, vout1.en} !== '0) begin
            n_bad++; $display("FAIL arst_out got col%h x%0d want col000 x0", {vout1.red, vout1.green, vout1.blue}, vout1.pxl_x);
        end
        n_cmp++;
        if ({busy1, done1, level1, busy4, done4, level4} !== {2'b00, 5'd16, 7'd0}) begin
            n_bad++; $display("FAIL arst_ctl got %b want %b", {busy1, done1, level1, busy4, done4, level4}, {2'b00, 5'd16, 7'd0});
        end
        step(); resetN = 1'b1; step(); step();
        n_cmp++;
        if ({busy1, level1, vout1.red, vout1.green, vout1.blue} !== {1'b0, 5'd16, 12'hF83}) begin
            n_bad++; $display("FAIL arst_after got busy%b lvl%0d col%h want busy0 lvl16 colF83", busy1, level1, {vout1.red, vout1.green, vout1.blue});
        end
    endtask

    initial begin
        test_reset();
        test_fade_out_step1();
        test_fade_in_step4();
        test_reversal();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
